mmio_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 28 ++
 rtl/byte_merge.sv | 22 ++
 rtl/mmio_timer.sv | 154 +++++++++++++++
 tb/tb_mmio_timer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
//   - FSM state encoding
//   - register offsets (word index addr[3:2])
//   - CTRL field positions and mode codes
package timer_pkg;

   typedef enum logic [1:0] {
      TS_IDLE = 2'd0,
      TS_LOAD = 2'd1,
      TS_CNT  = 2'd2,
      TS_INT  = 2'd3
   } timer_state_e;

   localparam logic [1:0] TOFF_CTRL   = 2'd0;
   localparam logic [1:0] TOFF_PRESET = 2'd1;
   localparam logic [1:0] TOFF_COUNT  = 2'd2;
   localparam logic [1:0] TOFF_RSVD   = 2'd3;

   localparam int unsigned TC_EN      = 0;
   localparam int unsigned TC_MODE_LO = 1;
   localparam int unsigned TC_MODE_HI = 2;
   localparam int unsigned TC_IM      = 3;
   localparam int unsigned TC_WIDTH   = 4;

   localparam logic [1:0] TMODE_ONESHOT = 2'd0;
   localparam logic [1:0] TMODE_RELOAD  = 2'd1;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane write merge (combinational).
//   old_i    : current 32-bit register value
//   wdata_i  : lane-aligned write data
//   byteen_i : per-byte write enables
//   merged_o : old_i with every enabled byte replaced from wdata_i
module byte_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  byteen_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < 4; i++) begin
         if (byteen_i[i]) begin
            merged_o[i*8 +: 8] = wdata_i[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer, responder on the M-stage data port.
//   clk, reset : single clock, synchronous active-high reset
//   addr       : byte address; window is BASE..BASE+'hF
//   wdata      : lane-aligned write data
//   byteen     : byte write enables (0 = no write)
//   rdata      : combinational read data (0 outside the window)
//   irq        : FLAG & IM
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO), 3 reserved.
// In auto-reload mode successive irq pulses are PRESET+2 cycles apart
// (LOAD, PRESET cycles of CNT, INT).
module mmio_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic        irq
);

   timer_state_e state_q, state_d;
   logic [TC_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [31:0]         preset_q, preset_d;
   logic [31:0]         count_q, count_d;
   logic                flag_q, flag_d;

   logic        hit, wr, wr_ctrl, wr_preset, force_idle;
   logic [1:0]  off;
   logic [31:0] ctrl_merged, preset_merged;
   logic        ctrl_en, ctrl_im;
   logic [1:0]  ctrl_mode;
   logic        unused_bits;

   assign hit       = (addr[31:4] == BASE[31:4]);
   assign off       = addr[3:2];
   assign wr        = hit && (byteen != 4'b0000);
   assign wr_ctrl   = wr && (off == TOFF_CTRL);
   assign wr_preset = wr && (off == TOFF_PRESET);

   assign ctrl_en   = ctrl_q[TC_EN];
   assign ctrl_im   = ctrl_q[TC_IM];
   assign ctrl_mode = ctrl_q[TC_MODE_HI:TC_MODE_LO];

   // A CTRL write that leaves EN low overrides whatever the FSM would do.
   assign force_idle = wr_ctrl && !ctrl_merged[TC_EN];

   assign unused_bits = ^{addr[1:0], ctrl_merged[31:TC_WIDTH]};

   byte_merge u_ctrl_merge (
      .old_i    ({{(32-TC_WIDTH){1'b0}}, ctrl_q}),
      .wdata_i  (wdata),
      .byteen_i (byteen),
      .merged_o (ctrl_merged)
   );

   byte_merge u_preset_merge (
      .old_i    (preset_q),
      .wdata_i  (wdata),
      .byteen_i (byteen),
      .merged_o (preset_merged)
   );

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= TS_IDLE;
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (force_idle) begin
         state_d = TS_IDLE;
      end else begin
         unique case (state_q)
            TS_IDLE: if (ctrl_en) state_d = TS_LOAD;
            TS_LOAD: state_d = TS_CNT;
            TS_CNT: begin
               if (!ctrl_en) begin
                  state_d = TS_IDLE;
               end else if (count_q <= 32'd1) begin
                  state_d = TS_INT;
               end
            end
            TS_INT: state_d = (ctrl_mode == TMODE_RELOAD) ? TS_LOAD : TS_IDLE;
         endcase
      end
   end

   // Datapath next values and outputs.
   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      // Any CTRL/PRESET write acknowledges a pending one-shot FLAG; a FLAG
      // raised by the FSM on the same edge still wins below.
      if (wr_ctrl || wr_preset) flag_d = 1'b0;

      if (!force_idle) begin
         unique case (state_q)
            TS_IDLE: ;
            TS_LOAD: count_d = preset_q;
            TS_CNT: begin
               if (ctrl_en) begin
                  if (count_q > 32'd1) begin
                     count_d = count_q - 32'd1;
                  end else begin
                     count_d = '0;
                     flag_d  = 1'b1;
                  end
               end
            end
            TS_INT: begin
               if (ctrl_mode == TMODE_RELOAD) flag_d = 1'b0;
               else                           ctrl_d[TC_EN] = 1'b0;
            end
         endcase
      end

      if (wr_preset) preset_d = preset_merged;
      // CPU value wins over the FSM's own EN clear.
      if (wr_ctrl)   ctrl_d   = ctrl_merged[TC_WIDTH-1:0];

      rdata = '0;
      if (hit) begin
         unique case (off)
            TOFF_CTRL:   rdata = {{(32-TC_WIDTH){1'b0}}, ctrl_q};
            TOFF_PRESET: rdata = preset_q;
            TOFF_COUNT:  rdata = count_q;
            TOFF_RSVD:   rdata = '0;
         endcase
      end

      irq = flag_q & ctrl_im;
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: the driver pushes the expected rdata/irq
// for every cycle from a behavioural model; a monitor pops and compares.
module tb_mmio_timer;

   localparam logic [31:0] TB_BASE = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL  = 32'h0000_7F00;
   localparam logic [31:0] A_PRE   = 32'h0000_7F04;
   localparam logic [31:0] A_CNT   = 32'h0000_7F08;
   localparam logic [31:0] A_RSV   = 32'h0000_7F0C;

   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_CNT  = 2;
   localparam int PH_INT  = 3;

   logic        clk;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  byteen;
   logic        irq;

   mmio_timer #(.BASE(TB_BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wdata  (wdata),
      .byteen (byteen),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] a;
      logic [31:0] rd;
      logic        irq;
      bit          lit_v;
      logic [31:0] lit;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   sb_en = 0;

   // Behavioural model state.
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   bit          m_flag;
   int          m_phase;

   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      return res;
   endfunction

   function automatic bit in_win(input logic [31:0] a);
      return (a >> 4) == (TB_BASE >> 4);
   endfunction

   function automatic int reg_idx(input logic [31:0] a);
      return int'((a & 32'hF) >> 2);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!in_win(a)) return 32'h0;
      case (reg_idx(a))
         0:       return {28'h0, m_ctrl};
         1:       return m_preset;
         2:       return m_count;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step(input bit r, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
      bit          w_c, w_p;
      logic [3:0]  nc;
      logic [31:0] np, ncnt;
      bit          nf;
      int          nph;
      if (r) begin
         m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = PH_IDLE;
         return;
      end
      w_c  = in_win(a) && be != 0 && reg_idx(a) == 0;
      w_p  = in_win(a) && be != 0 && reg_idx(a) == 1;
      nc   = m_ctrl; np = m_preset; ncnt = m_count; nf = m_flag; nph = m_phase;
      if (w_c || w_p) nf = 0;
      case (m_phase)
         PH_IDLE: if (m_ctrl[0]) nph = PH_LOAD;
         PH_LOAD: begin ncnt = m_preset; nph = PH_CNT; end
         PH_CNT: begin
            if (!m_ctrl[0]) nph = PH_IDLE;
            else if (m_count > 1) ncnt = m_count - 1;
            else begin ncnt = 0; nph = PH_INT; nf = 1; end
         end
         default: begin
            if (m_ctrl[2:1] == 2'd1) begin nph = PH_LOAD; nf = 0; end
            else begin nc[0] = 0; nph = PH_IDLE; end
         end
      endcase
      if (w_p) np = lane_merge(m_preset, wd, be);
      if (w_c) begin
         nc = lane_merge({28'h0, m_ctrl}, wd, be) & 32'hF;
         if (!nc[0]) begin nph = PH_IDLE; ncnt = m_count; nf = 0; end
      end
      m_ctrl = nc; m_preset = np; m_count = ncnt; m_flag = nf; m_phase = nph;
   endtask

   task automatic step(input bit r, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit lv, input logic [31:0] lit,
                       input string tag);
      exp_t e;
      reset = r; addr = a; wdata = wd; byteen = be;
      if (sb_en) begin
         e.tag = tag; e.a = a; e.rd = model_read(a); e.irq = m_flag & m_ctrl[3];
         e.lit_v = lv; e.lit = lit;
         exp_q.push_back(e);
      end
      @(posedge clk);
      model_step(r, a, wd, be);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      step(0, a, 32'h0, 4'h0, 0, 32'h0, tag);
   endtask

   task automatic rdl(input logic [31:0] a, input logic [31:0] lit, input string tag);
      step(0, a, 32'h0, 4'h0, 1, lit, tag);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input string tag);
      step(0, a, wd, be, 0, 32'h0, tag);
   endtask

   // Monitor: outputs are always valid, one expectation per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rdata !== e.rd || irq !== e.irq || (e.lit_v && rdata !== e.lit)) begin
               n_err++;
               $display("FAIL %s addr=%h: got rdata=%h irq=%b, required rdata=%h irq=%b%s",
                        e.tag, e.a, rdata, irq, e.rd, e.irq,
                        e.lit_v ? $sformatf(" (literal %h)", e.lit) : "");
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  be;
      int          o;
      m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = PH_IDLE;
      reset = 1; addr = 0; wdata = 0; byteen = 0;
      #1;
      step(1, A_CTRL, 32'h0, 4'h0, 0, 32'h0, "pre-reset");
      sb_en = 1;
      step(1, A_CTRL, 32'h0, 4'h0, 1, 32'h0, "reset");

      // Reset read-back
      rdl(A_CTRL, 32'h0, "rst_ctrl");
      rdl(A_PRE, 32'h0, "rst_preset");
      rdl(A_CNT, 32'h0, "rst_count");
      rdl(A_RSV, 32'h0, "rst_rsvd");
      rdl(32'h0000_3000, 32'h0, "out_of_window");

      // Byte-lane write
      wr(A_PRE, 32'hAABB_CCDD, 4'hF, "pre_full");
      wr(A_PRE, 32'h0000_1100, 4'b0010, "pre_lane1");
      rdl(A_PRE, 32'hAABB_11DD, "pre_merged");
      wr(A_CNT, 32'hFFFF_FFFF, 4'hF, "wr_count");
      rdl(A_CNT, 32'h0, "count_ro");

      // One-shot
      wr(A_PRE, 32'd5, 4'hF, "os_preset");
      wr(A_CTRL, 32'h9, 4'h1, "os_start");
      for (int i = 0; i < 12; i++) rd(A_CNT, "os_run");
      rdl(A_CTRL, 32'h8, "os_en_cleared");
      wr(A_CTRL, 32'h0, 4'h1, "os_ack");
      rd(A_CTRL, "os_after_ack");
      rd(A_CTRL, "os_after_ack");

      // Auto-reload
      wr(A_PRE, 32'd3, 4'hF, "ar_preset");
      wr(A_CTRL, 32'hB, 4'h1, "ar_start");
      for (int i = 0; i < 24; i++) rd(A_CNT, "ar_run");
      wr(A_CTRL, 32'h0, 4'h1, "ar_stop");

      // Stop mid-count, then re-enable
      wr(A_PRE, 32'd100, 4'hF, "stop_preset");
      wr(A_CTRL, 32'h9, 4'h1, "stop_start");
      for (int i = 0; i < 300 && !(m_phase == PH_CNT && m_count == 40); i++) rd(A_CNT, "stop_run");
      wr(A_CTRL, 32'h8, 4'h1, "stop_en0");
      rdl(A_CNT, 32'd40, "stop_hold");
      rdl(A_CNT, 32'd40, "stop_hold");
      rdl(A_CTRL, 32'h8, "stop_ctrl");
      wr(A_CTRL, 32'h9, 4'h1, "restart");
      rd(A_CNT, "restart_load");
      rd(A_CNT, "restart_load");
      rdl(A_CNT, 32'd100, "restart_reload");

      // Reset mid-count
      for (int i = 0; i < 300 && m_count != 7; i++) rd(A_CNT, "rst_wait");
      step(1, A_CNT, 32'h0, 4'h0, 0, 32'h0, "rst_mid");
      rdl(A_CNT, 32'h0, "rst_mid_count");
      rdl(A_CTRL, 32'h0, "rst_mid_ctrl");
      rdl(A_PRE, 32'h0, "rst_mid_preset");

      // PRESET write during CNT applies at next reload
      wr(A_PRE, 32'd20, 4'hF, "col_preset");
      wr(A_CTRL, 32'hB, 4'h1, "col_start");
      for (int i = 0; i < 300 && m_count != 15; i++) rd(A_CNT, "col_wait");
      wr(A_PRE, 32'd9, 4'hF, "col_preset9");
      for (int i = 0; i < 40; i++) rd(A_CNT, "col_run");
      wr(A_CTRL, 32'h0, 4'hF, "col_stop");

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         o  = int'($urandom_range(0, 3));
         a  = TB_BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) a = $urandom;
         be = 4'h0;
         wd = $urandom;
         if ($urandom_range(0, 99) < 20) begin
            be = 4'($urandom_range(1, 15));
            if (o == 0) wd[0] = ($urandom_range(0, 3) != 0);
            if (o == 1) wd = 32'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 199) == 0) step(1, a, wd, be, 0, 32'h0, "rnd_reset");
         else                             step(0, a, wd, be, 0, 32'h0, "rnd");
      end

      sb_en = 0;
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
